// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between host and uart_tx
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serialises bytes as start/8 data LSB first/optional odd parity/stop,
// with a one-entry holding register so frames can run back-to-back.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_16x,
  input  logic       parity_enable,
  uart_tx_if.slave   bus,
  output logic       tx_pin,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t         r_state, w_state;
  logic [7:0]     r_hold, w_hold, r_shift, w_shift;
  logic [2:0]     r_idx, w_idx;
  logic [OSW-1:0] r_os, w_os;
  logic           r_full, w_full, r_par_en, w_par_en, r_par, w_par;
  logic           r_stop, w_stop, r_pin, w_pin, r_done, w_done;
  logic           w_bit_end, w_last_stop, w_load, w_hs;
  assign w_bit_end   = (r_state != IDLE) && tick_16x && (r_os == OSW'(OVERSAMPLE - 1));
  assign w_last_stop = (r_state == STOP) && w_bit_end && (r_stop == 1'(STOP_BITS - 1));
  assign w_load      = r_full && tick_16x && ((r_state == IDLE) || w_last_stop);
  assign w_hs        = bus.tx_valid && !r_full;
  always_comb begin
    w_state  = r_state;
    w_shift  = r_shift;
    w_idx    = r_idx;
    w_par_en = r_par_en;
    w_par    = r_par;
    w_stop   = r_stop;
    w_done   = 1'b0;
    w_hold   = w_hs ? bus.tx_data : r_hold;
    w_full   = w_load ? 1'b0 : (r_full | w_hs);
    w_os     = (r_state != IDLE && tick_16x) ? (w_bit_end ? '0 : r_os + 1'b1) : r_os;
    case (r_state)
      START: if (w_bit_end) begin
        w_state = DATA;
        w_idx   = 3'd0;
      end
      DATA: if (w_bit_end) begin
        w_par = r_par ^ r_shift[r_idx];
        w_idx = r_idx + 1'b1;
        if (r_idx == 3'd7) begin
          w_state = r_par_en ? PARITY : STOP;
          w_stop  = 1'b0;
        end
      end
      PARITY: if (w_bit_end) begin
        w_state = STOP;
        w_stop  = 1'b0;
      end
      STOP: if (w_bit_end) begin
        w_stop = ~r_stop;
        if (w_last_stop) begin
          w_done  = 1'b1;
          w_state = IDLE;
        end
      end
      default: ;
    endcase
    // a load from the holding register overrides the return to IDLE
    if (w_load) begin
      w_state  = START;
      w_shift  = r_hold;
      w_par_en = parity_enable;
      w_par    = 1'b1;
      w_os     = '0;
      w_idx    = 3'd0;
      w_stop   = 1'b0;
    end
    w_pin = (w_state == START) ? 1'b0 :
            (w_state == DATA) ? w_shift[w_idx] :
            (w_state == PARITY) ? w_par : 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_hold   <= '0;
      r_shift  <= '0;
      r_idx    <= '0;
      r_os     <= '0;
      r_full   <= 1'b0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_stop   <= 1'b0;
      r_pin    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_hold   <= w_hold;
      r_shift  <= w_shift;
      r_idx    <= w_idx;
      r_os     <= w_os;
      r_full   <= w_full;
      r_par_en <= w_par_en;
      r_par    <= w_par;
      r_stop   <= w_stop;
      r_pin    <= w_pin;
      r_done   <= w_done;
    end
  end
  assign bus.tx_ready = ~r_full;
  assign tx_pin       = r_pin;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done      = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks on uart_tx (1 and 2 stop bits), tick every 4 clk.
module tb_uart_tx;
  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, par_en = 1'b0;
  logic [1:0] tcnt = 2'd0;
  logic pin1, busy1, done1, pin2, busy2, done2;
  logic d1_p = 1'b0, d2_p = 1'b0;
  int checks = 0, errors = 0, cyc = 0, wide = 0;
  int d1_n = 0, d1_t = 0, d2_n = 0, d2_t = 0;
  uart_tx_if bus1();
  uart_tx_if bus2();
  uart_tx #(.OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick), .parity_enable(par_en),
    .bus(bus1), .tx_pin(pin1), .tx_busy(busy1), .tx_done(done1));
  uart_tx #(.OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick), .parity_enable(par_en),
    .bus(bus2), .tx_pin(pin2), .tx_busy(busy2), .tx_done(done2));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    tcnt <= tcnt + 1'b1;
    tick <= (tcnt == 2'd3);
  end
  function automatic logic pin_of(input int s);
    return s != 0 ? pin2 : pin1;
  endfunction
  function automatic logic busy_of(input int s);
    return s != 0 ? busy2 : busy1;
  endfunction
  task step;
    @(negedge clk);
    cyc++;
    if (done1) begin
      if (d1_p) wide++;
      d1_n++;
      d1_t = cyc;
    end
    if (done2) begin
      if (d2_p) wide++;
      d2_n++;
      d2_t = cyc;
    end
    d1_p = done1;
    d2_p = done2;
  endtask
  task automatic send(input int s, input logic [7:0] d);
    int k = 0;
    step();
    if (s != 0) begin bus2.tx_data = d; bus2.tx_valid = 1'b1; end
    else begin bus1.tx_data = d; bus1.tx_valid = 1'b1; end
    while (!(s != 0 ? bus2.tx_ready : bus1.tx_ready) && k < 3000) begin step(); k++; end
    checks++;
    if (k >= 3000) begin errors++; $display("FAIL send_timeout dut%0d data %h never accepted", s, d); end
    @(posedge clk);
    #1;
    bus1.tx_valid = 1'b0;
    bus2.tx_valid = 1'b0;
  endtask
  task automatic wait_start(input int s, input int lim, output int t);
    int k = 0;
    while (pin_of(s) !== 1'b0 && k < lim) begin step(); k++; end
    checks++;
    if (k >= lim) begin errors++; $display("FAIL start_timeout dut%0d no start bit within %0d clk", s, lim); end
    t = cyc;
  endtask
  task automatic read_frame(input int s, input int t0, input int n, output logic [11:0] v, output int bb);
    v = '0;
    bb = 0;
    for (int i = 0; i < n; i++) begin
      while (cyc < t0 + 32 + 64 * i) step();
      v[i] = pin_of(s);
      if (busy_of(s) !== 1'b1) bb++;
    end
  endtask
  task test_reset;
    repeat (3) step();
    checks++;
    if (pin1 !== 1'b1) begin errors++; $display("FAIL reset_pin got %b exp 1", pin1); end
    checks++;
    if (bus1.tx_ready !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL reset_flags ready/busy/done got %b%b%b exp 100", bus1.tx_ready, busy1, done1);
    end
    reset_n = 1'b1;
    repeat (8) step();
  endtask
  task test_parity_frame;
    int t0, n0, bb;
    logic [11:0] v;
    par_en = 1'b1;
    n0 = d1_n;
    send(0, 8'h4E);
    wait_start(0, 200, t0);
    read_frame(0, t0, 11, v, bb);
    checks++;
    if (v[10:0] !== 11'b11010011100) begin errors++; $display("FAIL frame_4E got %b exp %b", v[10:0], 11'b11010011100); end
    checks++;
    if (bb != 0) begin errors++; $display("FAIL busy_4E low at %0d samples exp 0", bb); end
    while (cyc < t0 + 720) step();
    checks++;
    if (d1_n != n0 + 1 || d1_t != t0 + 704) begin
      errors++; $display("FAIL done_4E count %0d at %0d exp 1 at %0d", d1_n - n0, d1_t - t0, 704);
    end
    checks++;
    if (pin1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL idle_after_4E pin/busy %b%b exp 10", pin1, busy1); end
  endtask
  task test_no_parity;
    int t0, n0, bb;
    logic [11:0] v;
    par_en = 1'b0;
    n0 = d1_n;
    send(0, 8'h07);
    wait_start(0, 200, t0);
    par_en = 1'b1;
    read_frame(0, t0, 10, v, bb);
    checks++;
    if (v[9:0] !== 10'b1000001110) begin errors++; $display("FAIL frame_07 got %b exp %b", v[9:0], 10'b1000001110); end
    while (cyc < t0 + 700) step();
    checks++;
    if (d1_n != n0 + 1 || d1_t != t0 + 640) begin
      errors++; $display("FAIL done_07 count %0d at %0d exp 1 at %0d", d1_n - n0, d1_t - t0, 640);
    end
    checks++;
    if (pin1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL idle_after_07 pin/busy %b%b exp 10", pin1, busy1); end
  endtask
  task test_back_to_back;
    int t0, n0, bb, gap_bad, d_first;
    logic [11:0] v;
    logic pre;
    par_en = 1'b1;
    n0 = d1_n;
    gap_bad = 0;
    pre = 1'b0;
    send(0, 8'h55);
    wait_start(0, 200, t0);
    send(0, 8'hA3);
    read_frame(0, t0, 11, v, bb);
    checks++;
    if (v[10:0] !== 11'b11010101010) begin errors++; $display("FAIL frame_55 got %b exp %b", v[10:0], 11'b11010101010); end
    while (cyc < t0 + 704) begin
      step();
      if (busy1 !== 1'b1) gap_bad++;
      if (cyc == t0 + 703) pre = pin1;
    end
    d_first = d1_t;
    checks++;
    if (pre !== 1'b1 || pin1 !== 1'b0) begin
      errors++; $display("FAIL b2b_seam pin before/at %0d got %b%b exp 10", 704, pre, pin1);
    end
    read_frame(0, t0 + 704, 11, v, bb);
    checks++;
    if (v[10:0] !== 11'b11101000110) begin errors++; $display("FAIL frame_A3 got %b exp %b", v[10:0], 11'b11101000110); end
    gap_bad += bb;
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL b2b_busy low %0d times exp 0", gap_bad); end
    while (cyc < t0 + 1420) step();
    checks++;
    if (d1_n != n0 + 2 || d_first != t0 + 704 || d1_t != t0 + 1408) begin
      errors++; $display("FAIL b2b_done count %0d at %0d,%0d exp 2 at 704,1408", d1_n - n0, d_first - t0, d1_t - t0);
    end
  endtask
  task test_hold_swap;
    int t0, t2, bb, k, lows;
    logic [11:0] v;
    par_en = 1'b1;
    send(0, 8'h5A);
    wait_start(0, 200, t0);
    send(0, 8'hC3);
    step();
    bus1.tx_data = 8'hFF;
    bus1.tx_valid = 1'b1;
    read_frame(0, t0, 11, v, bb);
    checks++;
    if (v[10:0] !== 11'b11010110100) begin errors++; $display("FAIL frame_5A got %b exp %b", v[10:0], 11'b11010110100); end
    checks++;
    if (bus1.tx_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b exp 0", bus1.tx_ready); end
    bus1.tx_data = 8'h00;
    k = 0;
    while (bus1.tx_ready !== 1'b1 && k < 200) begin step(); k++; end
    @(posedge clk);
    #1;
    bus1.tx_valid = 1'b0;
    read_frame(0, t0 + 704, 11, v, bb);
    checks++;
    if (v[10:0] !== 11'b11110000110) begin errors++; $display("FAIL frame_C3 got %b exp %b", v[10:0], 11'b11110000110); end
    wait_start(0, 100, t2);
    checks++;
    if (t2 != t0 + 1408) begin errors++; $display("FAIL swap_start at %0d exp %0d", t2 - t0, 1408); end
    read_frame(0, t2, 11, v, bb);
    checks++;
    if (v[10:0] !== 11'b11000000000) begin errors++; $display("FAIL frame_00 got %b exp %b", v[10:0], 11'b11000000000); end
    lows = 0;
    repeat (800) begin step(); if (pin1 !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL no_dup line low %0d clk exp 0", lows); end
  endtask
  task test_reset_mid;
    int t0, n0, bb, lows;
    logic [11:0] v;
    par_en = 1'b1;
    send(0, 8'h81);
    wait_start(0, 200, t0);
    send(0, 8'h99);
    while (cyc < t0 + 32 + 256) step();
    checks++;
    if (pin1 !== 1'b0) begin errors++; $display("FAIL pre_reset_bit3 got %b exp 0", pin1); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pin1 !== 1'b1 || bus1.tx_ready !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL async_reset pin/ready/busy %b%b%b exp 110", pin1, bus1.tx_ready, busy1);
    end
    repeat (5) step();
    reset_n = 1'b1;
    lows = 0;
    repeat (300) begin step(); if (pin1 !== 1'b1 || busy1 !== 1'b0) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL post_reset_idle disturbed %0d clk exp 0", lows); end
    n0 = d1_n;
    send(0, 8'h3C);
    wait_start(0, 200, t0);
    read_frame(0, t0, 11, v, bb);
    checks++;
    if (v[10:0] !== 11'b11001111000) begin errors++; $display("FAIL frame_3C got %b exp %b", v[10:0], 11'b11001111000); end
    while (cyc < t0 + 720) step();
    checks++;
    if (d1_n != n0 + 1 || d1_t != t0 + 704) begin
      errors++; $display("FAIL done_3C count %0d at %0d exp 1 at %0d", d1_n - n0, d1_t - t0, 704);
    end
  endtask
  task test_two_stop;
    int t0, n0, bb;
    logic [11:0] v;
    par_en = 1'b1;
    n0 = d2_n;
    send(1, 8'h4E);
    wait_start(1, 200, t0);
    read_frame(1, t0, 12, v, bb);
    checks++;
    if (v !== 12'b111010011100) begin errors++; $display("FAIL frame_2stop got %b exp %b", v, 12'b111010011100); end
    while (cyc < t0 + 780) step();
    checks++;
    if (d2_n != n0 + 1 || d2_t != t0 + 768) begin
      errors++; $display("FAIL done_2stop count %0d at %0d exp 1 at %0d", d2_n - n0, d2_t - t0, 768);
    end
    checks++;
    if (pin2 !== 1'b1 || busy2 !== 1'b0) begin errors++; $display("FAIL idle_2stop pin/busy %b%b exp 10", pin2, busy2); end
  endtask
  initial begin
    bus1.tx_valid = 1'b0;
    bus1.tx_data = 8'h00;
    bus2.tx_valid = 1'b0;
    bus2.tx_data = 8'h00;
    test_reset();
    test_parity_frame();
    test_no_parity();
    test_back_to_back();
    test_hold_swap();
    test_reset_mid();
    test_two_stop();
    checks++;
    if (wide != 0) begin errors++; $display("FAIL done_width wide pulses %0d exp 0", wide); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the section-2 UART: it serialises one byte per frame onto `tx_pin` as start bit, 8 data bits LSB first, optional odd parity and stop bit(s), each bit lasting exactly `OVERSAMPLE` strobes of the shared `tick_16x` baud strobe. It pairs with `uart_rx` on the same tick generator, so a direct `tx_pin`→`rx_pin` loopback must yield error-free reception. A one-entry holding register lets the host queue the next byte while the current frame is on the wire, so frames go out back-to-back with no idle gap.

## Interface

- `OVERSAMPLE`, 16: `tick_16x` strobes per bit period.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk` input 1: system clock; all state changes on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `tick_16x` input 1: one-`clk` baud strobe at `OVERSAMPLE`× bit rate.
- `parity_enable` input 1: 1 inserts odd parity bit; sampled when a frame starts.
- `tx_data` input 8: byte to send; captured when `tx_valid && tx_ready`.
- `tx_valid` input 1: host has a byte on `tx_data`.
- `tx_ready` output 1: holding register empty; a byte may be accepted this cycle.
- `tx_pin` output 1: serial line, idle high; registered.
- `tx_busy` output 1: a frame is on the wire (state ≠ IDLE).
- `tx_done` output 1: one-`clk` pulse when the last stop bit period ends.

## Operation

- Holding register `hold_data` plus `hold_full`. `tx_ready = ~hold_full`. A handshake (`tx_valid && tx_ready` at a clock edge) loads `hold_data` and sets `hold_full`.
- Shift register `shift_data[7:0]`, bit index `bit_idx[2:0]`, oversample counter `os_count` (width `$clog2(OVERSAMPLE)`), stop counter, latched `par_en`, and running parity `par` are internal.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx_pin=1`. On a `tick_16x` with `hold_full`, the block moves `hold_data`→`shift_data`, clears `hold_full`, latches `parity_enable`, sets `par=1` (odd seed), `os_count=0`, and enters START.
  - START: `tx_pin=0`.
  - DATA: `tx_pin=shift_data[bit_idx]`, with `bit_idx` running 0..7. At each bit end, `par ^= current bit`.
  - PARITY: `tx_pin=par`. The line's total count of ones across data plus parity is odd. The state is skipped when `par_en=0`.
  - STOP: `tx_pin=1` for `STOP_BITS` bit periods.
- Bit end: `os_count` increments only on `tick_16x`. When `os_count==OVERSAMPLE-1` and `tick_16x` is high, `os_count` wraps to 0 and the FSM advances.
- Leaving STOP:
  - `tx_done` pulses.
  - If `hold_full` is set, the block loads the next byte and enters START on that same tick edge, giving zero idle gap.
  - Otherwise it returns to IDLE.
- Simultaneous handshake and load in the same cycle cannot occur, since a load requires `hold_full=1` and therefore `tx_ready=0`. A handshake during any frame state is legal and fills the register for the next frame.
- `tx_valid` with `tx_ready=0` is ignored and must not corrupt `hold_data`.
- Changing `parity_enable` mid-frame has no effect until the next frame start.

## Timing

- Reset (asynchronous, `reset_n=0`) forces, immediately and without waiting for `clk`: `tx_pin=1`, `tx_ready=1`, `tx_busy=0`, `tx_done=0`, state IDLE, `hold_full=0`, all counters 0. A frame in progress is abandoned and the queued byte is discarded.
- `tx_pin` changes only on a clock edge where `tick_16x=1` (or on reset). The output is glitch-free and registered.
- Each bit occupies exactly `OVERSAMPLE` ticks on the line. Frame length is `(1+8+par_en+STOP_BITS)·OVERSAMPLE` ticks.
- Latency from handshake to start bit: from 1 clk up to one tick period, set by the next `tick_16x` after `hold_full` sets.
- `tx_busy` rises on the same edge `tx_pin` falls for the start bit. It falls on the edge entering IDLE.
- `tx_done` is asserted on the final stop-bit tick edge and is high for exactly one `clk`.
- With tick period 4 clk and `OVERSAMPLE=16`, a bit lasts 64 clk; an 11-bit frame lasts 704 clk.

## Test plan

- Loopback into `uart_rx` with `parity_enable=1`, send 8'h4E: line reads 0,0,1,1,1,0,0,1,0,1(parity),1 at 64-clk spacing; rx gives `rx_data=8'h4E`, `data_ready=1`, `parity_err=0`, `frame_err=0`; one `tx_done` pulse 704 clk after start.
- `parity_enable=0`, send 8'h07: 10-bit frame, 640 clk; no parity slot; line is 0,1,1,1,0,0,0,0,0,1.
- Back-to-back: hand over 8'h55, then 8'hA3 while the first is busy. Require stop of frame 1 followed immediately by start of frame 2 with zero extra ticks, `tx_busy` high throughout, two `tx_done` pulses 704 clk apart, parity bit 1 on both.
- Hold `tx_valid=1` with 8'hFF while `tx_ready=0`, then swap to 8'h00 before it is accepted. Only the value present at the handshake edge is transmitted, and no byte is duplicated.
- Assert `reset_n=0` mid data bit 3 between clock edges. Require `tx_pin=1` and `tx_ready=1` before the next `clk` edge. After release, require an idle line and a clean subsequent 8'h3C frame.
- `STOP_BITS=2`: stop high for 128 clk, frame 768 clk with parity; rx reports `frame_err=0`.
